// File: rtl/pc_fetch_unit.sv
// PC register, next-PC selection and IF/ID pipeline register for the fetch stage.
// Optional macro PC_REDIRECT_CNT_EN adds a saturating 16-bit redirect counter output.
module pc_fetch_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        PC_Mux,
    input  logic [1:0]  target_sel,
    input  logic        reset_IF_ID,
    input  logic        LE,
    input  logic [31:0] branch_target,
    input  logic [31:0] jalr_target,
    input  logic [31:0] jal_target,
    input  logic [31:0] instr_in,
    output logic [31:0] pc_out,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic        misalign
`ifdef PC_REDIRECT_CNT_EN
    ,
    output logic [15:0] redirect_cnt
`endif
);

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state;
    logic        redirect;
    logic [31:0] target;

    // target_sel 11 means plain sequential fetch, so it never counts as a redirect
    always_comb begin
        redirect = PC_Mux && (target_sel != 2'b11);
        target   = jal_target;
        case (target_sel)
            2'b00:   target = branch_target;
            2'b01:   target = jalr_target & 32'hFFFF_FFFE;
            default: target = jal_target;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= BOOT;
            pc_out      <= 32'h0;
            if_id_pc    <= 32'h0;
            if_id_instr <= 32'h0;
            if_id_valid <= 1'b0;
            misalign    <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    state       <= RUN;
                    pc_out      <= 32'h0;
                    if_id_pc    <= 32'h0;
                    if_id_instr <= 32'h0;
                    if_id_valid <= 1'b0;
                end
                RUN: begin
                    // Flush wins over a stall; a redirect alone does not flush IF/ID
                    if (reset_IF_ID) begin
                        if_id_pc    <= 32'h0;
                        if_id_instr <= 32'h0;
                        if_id_valid <= 1'b0;
                    end else if (LE) begin
                        if_id_pc    <= pc_out;
                        if_id_instr <= instr_in;
                        if_id_valid <= 1'b1;
                    end

                    if (redirect) begin
                        pc_out <= target;
                        if (target[1:0] != 2'b00) begin
                            misalign <= 1'b1;
                        end
                    end else if (LE) begin
                        pc_out <= pc_out + 32'd4;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

`ifdef PC_REDIRECT_CNT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            redirect_cnt <= 16'h0;
        end else if ((state == RUN) && redirect && (redirect_cnt != 16'hFFFF)) begin
            redirect_cnt <= redirect_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: each driven cycle pushes the model's expected state,
// a monitor pops and compares it after the edge; scenario tasks add directed checks.
module tb_pc_fetch_unit;

    localparam logic [31:0] INSTR_KEY = 32'hDEAD_BEEF;

    logic        clk;
    logic        reset;
    logic        PC_Mux;
    logic [1:0]  target_sel;
    logic        reset_IF_ID;
    logic        LE;
    logic [31:0] branch_target;
    logic [31:0] jalr_target;
    logic [31:0] jal_target;
    logic [31:0] instr_in;
    logic [31:0] pc_out;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        misalign;
`ifdef PC_REDIRECT_CNT_EN
    logic [15:0] redirect_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ipc;
        logic [31:0] iinstr;
        logic        valid;
        logic        mis;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb_q[$];

    logic [31:0] m_pc     = 32'h0;
    logic [31:0] m_ipc    = 32'h0;
    logic [31:0] m_iinstr = 32'h0;
    logic        m_valid  = 1'b0;
    logic        m_mis    = 1'b0;
    logic        m_run    = 1'b0;
    logic [15:0] m_cnt    = 16'h0;

    pc_fetch_unit dut (
        .clk          (clk),
        .reset        (reset),
        .PC_Mux       (PC_Mux),
        .target_sel   (target_sel),
        .reset_IF_ID  (reset_IF_ID),
        .LE           (LE),
        .branch_target(branch_target),
        .jalr_target  (jalr_target),
        .jal_target   (jal_target),
        .instr_in     (instr_in),
        .pc_out       (pc_out),
        .if_id_pc     (if_id_pc),
        .if_id_instr  (if_id_instr),
        .if_id_valid  (if_id_valid),
        .misalign     (misalign)
`ifdef PC_REDIRECT_CNT_EN
        ,
        .redirect_cnt (redirect_cnt)
`endif
    );

    // Instruction memory stand-in: a fixed function of the fetch address
    assign instr_in = pc_out ^ INSTR_KEY;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, advance the model, queue its expectation, wait past the edge
    task automatic drive_cycle(input logic rst, input logic mux, input logic [1:0] sel,
                               input logic flush, input logic le, input logic [31:0] bt,
                               input logic [31:0] jrt, input logic [31:0] jlt);
        exp_t        e;
        logic        redir;
        logic [31:0] tgt;
        reset         = rst;
        PC_Mux        = mux;
        target_sel    = sel;
        reset_IF_ID   = flush;
        LE            = le;
        branch_target = bt;
        jalr_target   = jrt;
        jal_target    = jlt;
        redir = mux && (sel != 2'b11);
        tgt   = (sel == 2'b00) ? bt : (sel == 2'b01) ? {jrt[31:1], 1'b0} : jlt;
        if (!rst) begin
            m_pc = 32'h0; m_ipc = 32'h0; m_iinstr = 32'h0;
            m_valid = 1'b0; m_mis = 1'b0; m_run = 1'b0; m_cnt = 16'h0;
        end else if (!m_run) begin
            m_run = 1'b1;
        end else begin
            if (redir && (m_cnt != 16'hFFFF)) m_cnt = m_cnt + 16'd1;
            if (flush) begin
                m_ipc = 32'h0; m_iinstr = 32'h0; m_valid = 1'b0;
            end else if (le) begin
                m_ipc = m_pc; m_iinstr = m_pc ^ INSTR_KEY; m_valid = 1'b1;
            end
            if (redir) begin
                if (tgt[1:0] != 2'b00) m_mis = 1'b1;
                m_pc = tgt;
            end else if (le) begin
                m_pc = m_pc + 32'd4;
            end
        end
        e.pc = m_pc; e.ipc = m_ipc; e.iinstr = m_iinstr;
        e.valid = m_valid; e.mis = m_mis; e.cnt = m_cnt;
        sb_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // Scoreboard consumer: one expectation per active edge that had stimulus
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_checks += 5;
            if (pc_out !== e.pc) begin
                n_fail++; $display("[TB] FAIL sb_pc_out: got %h expected %h", pc_out, e.pc);
            end
            if (if_id_pc !== e.ipc) begin
                n_fail++; $display("[TB] FAIL sb_if_id_pc: got %h expected %h", if_id_pc, e.ipc);
            end
            if (if_id_instr !== e.iinstr) begin
                n_fail++; $display("[TB] FAIL sb_if_id_instr: got %h expected %h", if_id_instr, e.iinstr);
            end
            if (if_id_valid !== e.valid) begin
                n_fail++; $display("[TB] FAIL sb_if_id_valid: got %b expected %b", if_id_valid, e.valid);
            end
            if (misalign !== e.mis) begin
                n_fail++; $display("[TB] FAIL sb_misalign: got %b expected %b", misalign, e.mis);
            end
`ifdef PC_REDIRECT_CNT_EN
            n_checks++;
            if (redirect_cnt !== e.cnt) begin
                n_fail++; $display("[TB] FAIL sb_redirect_cnt: got %h expected %h", redirect_cnt, e.cnt);
            end
`endif
        end
    end

    task automatic test_reset();
        drive_cycle(1'b0, 1'b0, 2'b11, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
        drive_cycle(1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 32'h80, 32'h0, 32'h0);
        n_checks += 3;
        if (pc_out !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_pc: got %h expected %h", pc_out, 32'h0); end
        if (if_id_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b expected 0", if_id_valid); end
        if (misalign !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_misalign: got %b expected 0", misalign); end
        drive_cycle(1'b1, 1'b0, 2'b11, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
        n_checks += 2;
        if (pc_out !== 32'h0) begin n_fail++; $display("[TB] FAIL boot_pc: got %h expected %h", pc_out, 32'h0); end
        if (if_id_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL boot_valid: got %b expected 0", if_id_valid); end
        drive_cycle(1'b1, 1'b0, 2'b11, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
        n_checks += 2;
        if (pc_out !== 32'h4) begin n_fail++; $display("[TB] FAIL first_fetch_pc: got %h expected %h", pc_out, 32'h4); end
        if (if_id_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL first_fetch_valid: got %b expected 1", if_id_valid); end
        drive_cycle(1'b1, 1'b0, 2'b11, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
        n_checks++;
        if (pc_out !== 32'h8) begin n_fail++; $display("[TB] FAIL second_fetch_pc: got %h expected %h", pc_out, 32'h8); end
    endtask

    task automatic test_branch();
        drive_cycle(1'b1, 1'b0, 2'b11, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
        drive_cycle(1'b1, 1'b0, 2'b11, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
        drive_cycle(1'b1, 1'b1, 2'b00, 1'b1, 1'b1, 32'h80, 32'h0, 32'h0);
        n_checks += 2;
        if (pc_out !== 32'h80) begin n_fail++; $display("[TB] FAIL branch_pc: got %h expected %h", pc_out, 32'h80); end
        if (if_id_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL branch_flush_valid: got %b expected 0", if_id_valid); end
        drive_cycle(1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 32'h200, 32'h0, 32'h0);
        n_checks += 2;
        if (pc_out !== 32'h200) begin n_fail++; $display("[TB] FAIL wrong_path_pc: got %h expected %h", pc_out, 32'h200); end
        if (if_id_pc !== 32'h80) begin n_fail++; $display("[TB] FAIL wrong_path_capture: got %h expected %h", if_id_pc, 32'h80); end
    endtask

    task automatic test_jalr();
        drive_cycle(1'b1, 1'b1, 2'b01, 1'b0, 1'b1, 32'h0, 32'h101, 32'h0);
        n_checks += 2;
        if (pc_out !== 32'h100) begin n_fail++; $display("[TB] FAIL jalr_bit0_pc: got %h expected %h", pc_out, 32'h100); end
        if (misalign !== 1'b0) begin n_fail++; $display("[TB] FAIL jalr_aligned_flag: got %b expected 0", misalign); end
        drive_cycle(1'b1, 1'b1, 2'b01, 1'b0, 1'b1, 32'h0, 32'h102, 32'h0);
        drive_cycle(1'b1, 1'b0, 2'b11, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
        n_checks += 2;
        if (pc_out !== 32'h106) begin n_fail++; $display("[TB] FAIL jalr_misaligned_seq_pc: got %h expected %h", pc_out, 32'h106); end
        if (misalign !== 1'b1) begin n_fail++; $display("[TB] FAIL misalign_sticky: got %b expected 1", misalign); end
    endtask

    task automatic test_stall();
        drive_cycle(1'b0, 1'b0, 2'b11, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
        n_checks++;
        if (misalign !== 1'b0) begin n_fail++; $display("[TB] FAIL misalign_cleared: got %b expected 0", misalign); end
        drive_cycle(1'b1, 1'b0, 2'b11, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
        drive_cycle(1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 32'h0, 32'h0, 32'h20);
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
            n_checks += 2;
            if (pc_out !== 32'h20) begin n_fail++; $display("[TB] FAIL stall_pc_%0d: got %h expected %h", i, pc_out, 32'h20); end
            if (if_id_instr !== INSTR_KEY) begin n_fail++; $display("[TB] FAIL stall_if_id_%0d: got %h expected %h", i, if_id_instr, INSTR_KEY); end
        end
        drive_cycle(1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        drive_cycle(1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 32'h0, 32'h0, 32'h40);
        n_checks += 2;
        if (pc_out !== 32'h40) begin n_fail++; $display("[TB] FAIL stall_jal_pc: got %h expected %h", pc_out, 32'h40); end
        if (if_id_pc !== 32'h0) begin n_fail++; $display("[TB] FAIL stall_jal_if_id_hold: got %h expected %h", if_id_pc, 32'h0); end
        drive_cycle(1'b1, 1'b0, 2'b11, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
        n_checks++;
        if (if_id_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_over_stall: got %b expected 0", if_id_valid); end
    endtask

    task automatic test_wrap();
        drive_cycle(1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0, 32'h0);
        drive_cycle(1'b1, 1'b0, 2'b11, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
        n_checks += 2;
        if (pc_out !== 32'h0) begin n_fail++; $display("[TB] FAIL wrap_pc: got %h expected %h", pc_out, 32'h0); end
        if (if_id_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("[TB] FAIL wrap_if_id_pc: got %h expected %h", if_id_pc, 32'hFFFF_FFFC); end
    endtask

    task automatic test_reset_priority();
        drive_cycle(1'b1, 1'b0, 2'b11, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
        reset = 1'b0;
        #1;
        n_checks++;
        if (pc_out !== 32'h4) begin n_fail++; $display("[TB] FAIL reset_not_async: got %h expected %h", pc_out, 32'h4); end
        drive_cycle(1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 32'h80, 32'h0, 32'h0);
        n_checks++;
        if (pc_out !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_over_redirect: got %h expected %h", pc_out, 32'h0); end
        drive_cycle(1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 32'h80, 32'h0, 32'h0);
        n_checks++;
        if (pc_out !== 32'h0) begin n_fail++; $display("[TB] FAIL boot_ignores_redirect: got %h expected %h", pc_out, 32'h0); end
        drive_cycle(1'b1, 1'b0, 2'b11, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 150; i++) begin
            drive_cycle(1'b1, ($urandom_range(3) == 0), 2'($urandom_range(3)),
                        ($urandom_range(9) == 0), ($urandom_range(3) != 0),
                        $urandom & 32'hFFFF_FFFC, $urandom, $urandom);
        end
    endtask

`ifdef PC_REDIRECT_CNT_EN
    task automatic test_redirect_cnt();
        drive_cycle(1'b0, 1'b0, 2'b11, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
        drive_cycle(1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 32'h40, 32'h0, 32'h0);
        drive_cycle(1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 32'h40, 32'h0, 32'h0);
        drive_cycle(1'b1, 1'b1, 2'b01, 1'b0, 1'b1, 32'h0, 32'h81, 32'h0);
        drive_cycle(1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 32'h0, 32'h0, 32'hC0);
        drive_cycle(1'b1, 1'b1, 2'b11, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
        n_checks++;
        if (redirect_cnt !== 16'd3) begin n_fail++; $display("[TB] FAIL redirect_cnt_three: got %h expected %h", redirect_cnt, 16'd3); end
        force dut.redirect_cnt = 16'hFFFF;
        #1;
        release dut.redirect_cnt;
        m_cnt = 16'hFFFF;
        drive_cycle(1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 32'h100, 32'h0, 32'h0);
        n_checks++;
        if (redirect_cnt !== 16'hFFFF) begin n_fail++; $display("[TB] FAIL redirect_cnt_saturate: got %h expected %h", redirect_cnt, 16'hFFFF); end
    endtask
`endif

    initial begin
        reset = 1'b0; PC_Mux = 1'b0; target_sel = 2'b11; reset_IF_ID = 1'b0; LE = 1'b0;
        branch_target = 32'h0; jalr_target = 32'h0; jal_target = 32'h0;
        @(negedge clk);
        test_reset();
        test_branch();
        test_jalr();
        test_stall();
        test_wrap();
        test_reset_priority();
        test_random();
`ifdef PC_REDIRECT_CNT_EN
        test_redirect_cnt();
`endif
        @(posedge clk);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
